stack_sequencer: RTL and testbench

//  Multi-cycle controller for SM83 stack ops (PUSH/POP/CALL/RET/RETI) over an 8-bit memory port.

---
 rtl/cu_pkg.sv | 9 +
 rtl/stack_sequencer_mem_port.sv | 29 ++
 rtl/stack_sequencer.sv | 136 +++++++++++++
 tb/tb_stack_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: control-unit types shared by the stack sequencer and its memory port.
package cu_pkg;
  typedef enum logic [2:0] {OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RETI, OP_IRQ} stack_op_t;
  typedef enum logic [1:0] {PAIR_BC, PAIR_DE, PAIR_HL, PAIR_AF} stack_pair_t;
  typedef enum logic [2:0] {S_IDLE, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI, S_WB_REG, S_WB} stack_state_t;
  function automatic logic is_push(stack_op_t op);
    return op inside {OP_PUSH, OP_CALL, OP_IRQ};
  endfunction
endpackage

// File: rtl/stack_sequencer_mem_port.sv
// stack_mem_port: drives one byte request, reports its ack and keeps the last byte read.
module stack_mem_port #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              ack,
  output logic [DATA_W-1:0] rbyte
);
  assign mem_req_o   = req;
  assign mem_we_o    = req & we;
  assign mem_addr_o  = req ? addr : '0;
  assign mem_wdata_o = (req & we) ? wdata : '0;
  assign ack         = req & mem_ack_i;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) rbyte <= '0;
    else if (ack && !we) rbyte <= mem_rdata_i;
endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle SM83 PUSH/POP/CALL/RET/RETI controller over a byte-wide memory port.
// STACK_SEQ_IRQ_EN adds the IRQ op (CALL to a fixed vector) with irq_vec_i and ime_clr_o.
module stack_sequencer import cu_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_i,
  input  stack_op_t         op_i,
  input  stack_pair_t       pair_i,
  input  logic [ADDR_W-1:0] sp_i,
  input  logic [ADDR_W-1:0] pair_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] target_i,
`ifdef STACK_SEQ_IRQ_EN
  input  logic [2:0]        irq_vec_i,
  output logic              ime_clr_o,
`endif
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              rf_we_o,
  output stack_pair_t       rf_sel_o,
  output logic [ADDR_W-1:0] rf_wdata_o,
  output logic              sp_we_o,
  output logic [ADDR_W-1:0] sp_next_o,
  output logic              pc_we_o,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              ime_set_o,
  output logic              busy_o,
  output logic              done_o
);
  stack_state_t state, state_nx;
  stack_op_t op_q;
  stack_pair_t pair_q;
  logic [ADDR_W-1:0] sp_q, val_q, tgt_q, call_pc, addr;
  logic [DATA_W-1:0] wdata, rbyte;
  logic legal, accept, req, we, ack;
`ifdef STACK_SEQ_IRQ_EN
  assign legal     = op_i inside {OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RETI, OP_IRQ};
  assign call_pc   = op_i == OP_IRQ ? ADDR_W'({2'b01, irq_vec_i, 3'b000}) : target_i;
  assign ime_clr_o = accept && op_i == OP_IRQ;
`else
  assign legal   = op_i inside {OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_RETI};
  assign call_pc = target_i;
`endif
  assign accept = state == S_IDLE && start_i && legal;
  assign busy_o = state != S_IDLE;
  stack_mem_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
    .clk(clk), .nrst(nrst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .ack(ack), .rbyte(rbyte)
  );
  // val_q holds the word to push, then is reused for the word popped
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state  <= S_IDLE;
      op_q   <= OP_PUSH;
      pair_q <= PAIR_BC;
      sp_q   <= '0;
      val_q  <= '0;
      tgt_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= op_i;
        pair_q <= pair_i;
        sp_q   <= sp_i;
        val_q  <= op_i == OP_PUSH ? pair_data_i : pc_i;
        tgt_q  <= call_pc;
      end else if (ack && state == S_RD_HI) val_q <= {mem_rdata_i, rbyte};
    end
  always_comb begin
    state_nx   = state;
    req        = 1'b0;
    we         = 1'b0;
    addr       = '0;
    wdata      = '0;
    rf_we_o    = 1'b0;
    rf_sel_o   = PAIR_BC;
    rf_wdata_o = '0;
    sp_we_o    = 1'b0;
    sp_next_o  = '0;
    pc_we_o    = 1'b0;
    pc_next_o  = '0;
    ime_set_o  = 1'b0;
    done_o     = 1'b0;
    case (state)
      S_IDLE: if (accept) state_nx = is_push(op_i) ? S_WR_HI : S_RD_LO;
      S_WR_HI: begin
        req      = 1'b1;
        we       = 1'b1;
        addr     = sp_q - ADDR_W'(1);
        wdata    = val_q[ADDR_W-1 -: DATA_W];
        state_nx = ack ? S_WR_LO : state;
      end
      S_WR_LO: begin
        req      = 1'b1;
        we       = 1'b1;
        addr     = sp_q - ADDR_W'(2);
        wdata    = val_q[DATA_W-1:0];
        state_nx = ack ? S_WB : state;
      end
      S_RD_LO: begin
        req      = 1'b1;
        addr     = sp_q;
        state_nx = ack ? S_RD_HI : state;
      end
      S_RD_HI: begin
        req      = 1'b1;
        addr     = sp_q + ADDR_W'(1);
        state_nx = ack ? (op_q == OP_POP ? S_WB_REG : S_WB) : state;
      end
      S_WB_REG: begin
        rf_we_o    = 1'b1;
        rf_sel_o   = pair_q;
        rf_wdata_o = pair_q == PAIR_AF ? {val_q[ADDR_W-1:4], 4'h0} : val_q;
        state_nx   = S_WB;
      end
      S_WB: begin
        sp_we_o   = 1'b1;
        sp_next_o = is_push(op_q) ? sp_q - ADDR_W'(2) : sp_q + ADDR_W'(2);
        pc_we_o   = !(op_q inside {OP_PUSH, OP_POP});
        pc_next_o = pc_we_o ? (is_push(op_q) ? tgt_q : val_q) : '0;
        ime_set_o = op_q == OP_RETI;
        done_o    = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer: directed and randomized stack ops checked against a transaction-level stack model.
`timescale 1ns/1ps
module tb_stack_sequencer;
  import cu_pkg::*;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, ack = 1'b0;
  stack_op_t op = OP_PUSH;
  stack_pair_t pair = PAIR_BC, rf_sel;
  logic [15:0] sp = '0, pdata = '0, pc = '0, tgt = '0;
  logic [15:0] addr, rf_wdata, sp_next, pc_next;
  logic [7:0] rdata, wdata;
  logic req, we, rf_we, sp_we, pc_we, ime_set, busy, done;
`ifdef STACK_SEQ_IRQ_EN
  logic [2:0] vec = '0;
  logic ime_clr;
`endif
  logic [7:0] mem [0:65535];
  int lat = 0, wcnt = 0, nwr = 0;
  int checks = 0, errors = 0;
  int n, n_rf, n_sp, n_pc, n_ime, stab_err, ovl_err, busy_err;
  logic [15:0] o_rf, o_sp, o_pc;
  stack_pair_t o_sel;
  logic o_clr;

  stack_sequencer dut (
    .clk(clk), .nrst(nrst), .start_i(start), .op_i(op), .pair_i(pair), .sp_i(sp),
    .pair_data_i(pdata), .pc_i(pc), .target_i(tgt),
`ifdef STACK_SEQ_IRQ_EN
    .irq_vec_i(vec), .ime_clr_o(ime_clr),
`endif
    .mem_ack_i(ack), .mem_rdata_i(rdata), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr),
    .mem_wdata_o(wdata), .rf_we_o(rf_we), .rf_sel_o(rf_sel), .rf_wdata_o(rf_wdata),
    .sp_we_o(sp_we), .sp_next_o(sp_next), .pc_we_o(pc_we), .pc_next_o(pc_next),
    .ime_set_o(ime_set), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;
  assign rdata = mem[addr];

  // byte memory with 'lat' wait cycles before each ack
  always @(negedge clk)
    if (req && wcnt >= lat) begin
      ack = 1'b1;
      wcnt = 0;
      if (we) begin
        mem[addr] = wdata;
        nwr++;
      end
    end else begin
      ack = 1'b0;
      if (req) wcnt++;
    end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(stack_op_t o, stack_pair_t p, logic [15:0] s, d, c, t, int l, logic [2:0] v);
    logic [15:0] s1, s2, sp1, val, e_sp, e_pc, e_rf, padr;
    logic [7:0] lo, hi, pwd;
    logic preq, pack, pwe;
    bit wr, pw, seen;
    int e_n;
    string nm;
    nm = o.name();
    s1 = s - 16'd1; s2 = s - 16'd2; sp1 = s + 16'd1;
    wr = o inside {OP_PUSH, OP_CALL, OP_IRQ};
    pw = !(o inside {OP_PUSH, OP_POP});
    lo = mem[s]; hi = mem[sp1];
    val  = o == OP_PUSH ? d : c;
    e_sp = wr ? s2 : s + 16'd2;
    e_pc = o == OP_CALL ? t : o == OP_IRQ ? 16'h0040 + 16'(v) * 16'd8 : {hi, lo};
    e_rf = p == PAIR_AF ? {hi, lo} & 16'hFFF0 : {hi, lo};
    e_n  = 2 * (l + 1) + (o == OP_POP ? 2 : 1);
    {n_rf, n_sp, n_pc, n_ime, stab_err, ovl_err, busy_err} = '0;
    {preq, pack, pwe, padr, pwd, seen, o_clr} = '0;
    @(negedge clk);
    lat = l; wcnt = 0; nwr = 0;
    op = o; pair = p; sp = s; pdata = d; pc = c; tgt = t; start = 1'b1;
`ifdef STACK_SEQ_IRQ_EN
    vec = v;
    #1 o_clr = ime_clr;
`endif
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100) begin
      #1 n++;
      if (!busy) busy_err++;
      if (preq && !pack && (!req || addr !== padr || we !== pwe || wdata !== pwd)) stab_err++;
      if (rf_we) begin
        n_rf++; o_rf = rf_wdata; o_sel = rf_sel;
        if (sp_we || pc_we) ovl_err++;
      end
      if (pc_we && !sp_we) ovl_err++;
      if (sp_we) begin n_sp++; o_sp = sp_next; end
      if (pc_we) begin n_pc++; o_pc = pc_next; end
      if (ime_set) n_ime++;
      {preq, pack, padr, pwe, pwd} = {req, ack, addr, we, wdata};
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk({nm, ".done"}, seen, 1'b1);
    chk({nm, ".latency"}, n, e_n);
    chk({nm, ".sp_we_cnt"}, n_sp, 1);
    chk({nm, ".sp_next"}, o_sp, e_sp);
    chk({nm, ".pc_we_cnt"}, n_pc, pw);
    if (pw) chk({nm, ".pc_next"}, o_pc, e_pc);
    chk({nm, ".rf_we_cnt"}, n_rf, o == OP_POP);
    if (o == OP_POP) begin
      chk({nm, ".rf_wdata"}, o_rf, e_rf);
      chk({nm, ".rf_sel"}, o_sel, p);
    end
    chk({nm, ".ime_set_cnt"}, n_ime, o == OP_RETI);
`ifdef STACK_SEQ_IRQ_EN
    chk({nm, ".ime_clr"}, o_clr, o == OP_IRQ);
`endif
    chk({nm, ".mem_writes"}, nwr, wr ? 2 : 0);
    if (wr) begin
      chk({nm, ".mem_hi"}, mem[s1], val[15:8]);
      chk({nm, ".mem_lo"}, mem[s2], val[7:0]);
    end
    chk({nm, ".req_stable"}, stab_err, 0);
    chk({nm, ".strobe_overlap"}, ovl_err, 0);
    chk({nm, ".busy_during"}, busy_err, 0);
    @(negedge clk);
    #1 chk({nm, ".idle_after"}, {busy, done, sp_we, pc_we, rf_we}, 0);
  endtask

  initial begin
    int strobes;
    int k0;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctl", {req, we, rf_we, sp_we, pc_we, ime_set, busy, done}, 0);
    chk("rst_addr", {addr, wdata}, 0);
    chk("rst_rf", {rf_sel, rf_wdata}, 0);
    chk("rst_sp_pc", {sp_next, pc_next}, 0);
    @(negedge clk);
    nrst = 1'b1;
    // 1: PUSH BC, zero wait
    run_op(OP_PUSH, PAIR_BC, 16'hFFFE, 16'h1234, 16'h0, 16'h0, 0, 3'd0);
    chk("t1_mem_fffd", mem[16'hFFFD], 8'h12);
    chk("t1_mem_fffc", mem[16'hFFFC], 8'h34);
    chk("t1_sp", o_sp, 16'hFFFC);
    chk("t1_latency", n, 3);
    // 2: POP AF masks the low flag nibble
    mem[16'hC000] = 8'hFF; mem[16'hC001] = 8'hAB;
    run_op(OP_POP, PAIR_AF, 16'hC000, 16'h0, 16'h0, 16'h0, 0, 3'd0);
    chk("t2_rf", o_rf, 16'hABF0);
    chk("t2_sel", o_sel, PAIR_AF);
    chk("t2_sp", o_sp, 16'hC002);
    chk("t2_latency", n, 4);
    // 3: CALL with two wait cycles per access
    run_op(OP_CALL, PAIR_BC, 16'hD000, 16'h0, 16'h0203, 16'h0150, 2, 3'd0);
    chk("t3_mem_cfff", mem[16'hCFFF], 8'h02);
    chk("t3_mem_cffe", mem[16'hCFFE], 8'h03);
    chk("t3_pc", o_pc, 16'h0150);
    chk("t3_sp", o_sp, 16'hCFFE);
    chk("t3_latency", n, 7);
    // 4: RETI wrapping past 0xFFFF
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    run_op(OP_RETI, PAIR_BC, 16'hFFFF, 16'h0, 16'h0, 16'h0, 0, 3'd0);
    chk("t4_pc", o_pc, 16'h1234);
    chk("t4_sp", o_sp, 16'h0001);
    chk("t4_ime", n_ime, 1);
    // PUSH at SP=0 wraps downward
    run_op(OP_PUSH, PAIR_HL, 16'h0000, 16'hABCD, 16'h0, 16'h0, 1, 3'd0);
    chk("wrap_mem_ffff", mem[16'hFFFF], 8'hAB);
    chk("wrap_mem_fffe", mem[16'hFFFE], 8'hCD);
    chk("wrap_sp", o_sp, 16'hFFFE);
    // 5: start while busy is ignored; reset in RD_HI issues no writes
    @(negedge clk);
    lat = 0; wcnt = 0; nwr = 0; strobes = 0; busy_err = 0;
    op = OP_POP; pair = PAIR_DE; sp = 16'h4000; start = 1'b1;
    @(negedge clk);
    op = OP_PUSH; pdata = 16'hBEEF; sp = 16'h8000;
    @(negedge clk);
    #1;
    chk("t5_busy_start_we", we, 1'b0);
    chk("t5_busy_start_addr", addr, 16'h4001);
    start = 1'b0; nrst = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_req", req, 1'b0);
    repeat (2) begin
      @(negedge clk); #1;
      if (rf_we || sp_we || pc_we || done || ime_set) strobes++;
    end
    nrst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      if (rf_we || sp_we || pc_we || done || ime_set) strobes++;
      if (busy) busy_err++;
    end
    chk("t5_no_writeback", strobes, 0);
    chk("t5_no_mem_write", nwr, 0);
    chk("t5_idle_after_rst", busy_err, 0);
    // 6: IRQ vector and illegal ops
`ifdef STACK_SEQ_IRQ_EN
    run_op(OP_IRQ, PAIR_BC, 16'hD000, 16'h0, 16'h0300, 16'h1111, 0, 3'd2);
    chk("t6_irq_pc", o_pc, 16'h0050);
    chk("t6_ime_clr", o_clr, 1'b1);
    k0 = 6;
`else
    k0 = 5;
`endif
    for (int k = k0; k < 8; k++) begin
      busy_err = 0;
      @(negedge clk);
      op = stack_op_t'(3'(k)); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
        #1 if (busy || req) busy_err++;
        @(negedge clk);
      end
      chk($sformatf("t6_illegal_op%0d", k), busy_err, 0);
    end
    // randomized ops against the stack model
    for (int i = 0; i < 30; i++) begin
      stack_op_t o;
      logic [15:0] s, s1;
`ifdef STACK_SEQ_IRQ_EN
      o = stack_op_t'(3'($urandom_range(0, 5)));
`else
      o = stack_op_t'(3'($urandom_range(0, 4)));
`endif
      s = 16'($urandom);
      s1 = s + 16'd1;
      mem[s] = 8'($urandom);
      mem[s1] = 8'($urandom);
      run_op(o, stack_pair_t'(2'($urandom_range(0, 3))), s, 16'($urandom), 16'($urandom),
             16'($urandom), $urandom_range(0, 2), 3'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
